// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the RV32I decode/operand stage.
//   - Opcode constants for the instruction classes the stage decodes
//   - Immediate-format and operand-select enums
//   - Per-opcode decode record and its lookup function
package id_operand_stage_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned RA_W_DEF = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;
  typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_UIMM} op1_sel_e;
  typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IIMM, OP2_PC} op2_sel_e;

  typedef struct packed {
    logic     known;
    logic     use_rs1;
    logic     use_rs2;
    logic     wen;
    logic     imm_en;
    imm_fmt_e fmt;
    op1_sel_e op1_sel;
    op2_sel_e op2_sel;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] opc);
    dec_t d;
    d = '0;
    d.fmt     = IMM_I;
    d.op1_sel = OP1_ZERO;
    d.op2_sel = OP2_ZERO;
    case (opc)
      OPC_LUI: begin
        d.known = 1'b1; d.wen = 1'b1; d.imm_en = 1'b1; d.fmt = IMM_U;
        d.op1_sel = OP1_UIMM;
      end
      OPC_AUIPC: begin
        d.known = 1'b1; d.wen = 1'b1; d.imm_en = 1'b1; d.fmt = IMM_U;
        d.op1_sel = OP1_UIMM; d.op2_sel = OP2_PC;
      end
      OPC_JAL: begin
        d.known = 1'b1; d.wen = 1'b1; d.imm_en = 1'b1; d.fmt = IMM_J;
      end
      OPC_JALR, OPC_LOAD: begin
        d.known = 1'b1; d.wen = 1'b1; d.imm_en = 1'b1; d.fmt = IMM_I;
        d.use_rs1 = 1'b1; d.op1_sel = OP1_RS1;
      end
      OPC_OPIMM: begin
        d.known = 1'b1; d.wen = 1'b1; d.imm_en = 1'b1; d.fmt = IMM_I;
        d.use_rs1 = 1'b1; d.op1_sel = OP1_RS1; d.op2_sel = OP2_IIMM;
      end
      OPC_BRANCH: begin
        d.known = 1'b1; d.imm_en = 1'b1; d.fmt = IMM_B;
        d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
        d.op1_sel = OP1_RS1; d.op2_sel = OP2_RS2;
      end
      OPC_STORE: begin
        d.known = 1'b1; d.imm_en = 1'b1; d.fmt = IMM_S;
        d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
        d.op1_sel = OP1_RS1; d.op2_sel = OP2_RS2;
      end
      OPC_OP: begin
        d.known = 1'b1; d.wen = 1'b1;
        d.use_rs1 = 1'b1; d.use_rs2 = 1'b1;
        d.op1_sel = OP1_RS1; d.op2_sel = OP2_RS2;
      end
      default: d = d;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_operand_stage_fwd_resolve.sv
// Priority bypass resolution for one source operand.
//   en          source is used by the instruction
//   addr        source register address
//   rf_data     regfile read data for addr
//   fwd_*       packed bypass channels, channel 0 = youngest / highest priority
//   value       resolved operand
//   hazard      matching youngest producer has not produced its result yet
module fwd_resolve
  #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned NUM_FWD = 3
  )
  (
    input  logic                    en,
    input  logic [RA_W-1:0]         addr,
    input  logic [XLEN-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic [NUM_FWD*RA_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]         value,
    output logic                    hazard
  );

  logic found;

  always_comb begin
    value  = rf_data;
    hazard = 1'b0;
    found  = 1'b0;
    // The first match claims the operand; a pending youngest producer stalls
    // even if an older channel holds a stale copy of the same register.
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (!found && fwd_valid[i] && (fwd_addr[i*RA_W +: RA_W] == addr)) begin
        found  = 1'b1;
        hazard = fwd_pending[i];
        value  = fwd_data[i*XLEN +: XLEN];
      end
    end
    if (!en || (addr == '0)) begin
      value  = '0;
      hazard = 1'b0;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// RV32I decode/operand stage between IF/ID and EX.
//   in_*        instruction from IF/ID (valid/ready handshake)
//   rf_rd*      combinational regfile read ports
//   fwd_*       NUM_FWD prioritised bypass channels (0 = youngest)
//   out_*       registered ID/EX slot (valid/ready handshake)
//   flush       kills the held and the incoming instruction
//   stall_cnt   saturating count of hazard stall cycles
module id_operand_stage
  import id_operand_stage_pkg::*;
  #(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned RA_W    = RA_W_DEF,
    parameter int unsigned NUM_FWD = 3,
    parameter int unsigned CNT_W   = 16
  )
  (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_pc,
    input  logic [31:0]             in_instr,
    input  logic                    in_pred,
    output logic                    rf_rd1_en,
    output logic                    rf_rd2_en,
    output logic [RA_W-1:0]         rf_rd1_addr,
    output logic [RA_W-1:0]         rf_rd2_addr,
    input  logic [XLEN-1:0]         rf_rd1_data,
    input  logic [XLEN-1:0]         rf_rd2_data,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic [NUM_FWD*RA_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_instr,
    output logic                    out_pred,
    output logic [XLEN-1:0]         out_op1,
    output logic [XLEN-1:0]         out_op2,
    output logic [XLEN-1:0]         out_imm,
    output logic [RA_W-1:0]         out_rd,
    output logic                    out_wen,
    output logic [CNT_W-1:0]        stall_cnt
  );

  dec_t            dec;
  logic            use1, use2;
  logic            haz1, haz2, hazard;
  logic [RA_W-1:0] rs1, rs2, rd;
  logic [XLEN-1:0] src1, src2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
  logic [XLEN-1:0] op1_val, op2_val;
  logic            accept;

  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_pc_q, out_pc_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic            out_pred_q, out_pred_d;
  logic [XLEN-1:0] out_op1_q, out_op1_d;
  logic [XLEN-1:0] out_op2_q, out_op2_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic [RA_W-1:0] out_rd_q, out_rd_d;
  logic            out_wen_q, out_wen_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    dec  = decode(in_instr[6:0]);
    rs1  = RA_W'(in_instr[19:15]);
    rs2  = RA_W'(in_instr[24:20]);
    rd   = RA_W'(in_instr[11:7]);
    use1 = in_valid & dec.use_rs1;
    use2 = in_valid & dec.use_rs2;
  end

  assign rf_rd1_en   = use1;
  assign rf_rd2_en   = use2;
  assign rf_rd1_addr = use1 ? rs1 : '0;
  assign rf_rd2_addr = use2 ? rs2 : '0;

  fwd_resolve #(.XLEN(XLEN), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_fwd1 (
    .en          (use1),
    .addr        (rf_rd1_addr),
    .rf_data     (rf_rd1_data),
    .fwd_valid   (fwd_valid),
    .fwd_pending (fwd_pending),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .value       (src1),
    .hazard      (haz1)
  );

  fwd_resolve #(.XLEN(XLEN), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_fwd2 (
    .en          (use2),
    .addr        (rf_rd2_addr),
    .rf_data     (rf_rd2_data),
    .fwd_valid   (fwd_valid),
    .fwd_pending (fwd_pending),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .value       (src2),
    .hazard      (haz2)
  );

  assign hazard = haz1 | haz2;

  always_comb begin
    imm_i = XLEN'($signed(in_instr[31:20]));
    imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0}));
    imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
    imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                           in_instr[30:21], 1'b0}));
    imm_sel = '0;
    if (dec.imm_en) begin
      case (dec.fmt)
        IMM_I:   imm_sel = imm_i;
        IMM_S:   imm_sel = imm_s;
        IMM_B:   imm_sel = imm_b;
        IMM_U:   imm_sel = imm_u;
        IMM_J:   imm_sel = imm_j;
        default: imm_sel = '0;
      endcase
    end

    case (dec.op1_sel)
      OP1_RS1:  op1_val = src1;
      OP1_UIMM: op1_val = imm_u;
      default:  op1_val = '0;
    endcase

    case (dec.op2_sel)
      OP2_RS2:  op2_val = src2;
      OP2_IIMM: op2_val = imm_i;
      OP2_PC:   op2_val = XLEN'(in_pc);
      default:  op2_val = '0;
    endcase
  end

  assign in_ready = rst & ~flush & ~hazard & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_pred_d  = out_pred_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    out_imm_d   = out_imm_q;
    out_rd_d    = out_rd_q;
    out_wen_d   = out_wen_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_pc_d    = in_pc;
      out_instr_d = in_instr;
      out_pred_d  = in_pred;
      out_op1_d   = op1_val;
      out_op2_d   = op2_val;
      out_imm_d   = imm_sel;
      out_rd_d    = dec.known ? rd : '0;
      out_wen_d   = dec.wen & (rd != '0);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_valid && hazard && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_pred_q  <= 1'b0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_imm_q   <= '0;
      out_rd_q    <= '0;
      out_wen_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_pred_q  <= out_pred_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      out_imm_q   <= out_imm_d;
      out_rd_q    <= out_rd_d;
      out_wen_q   <= out_wen_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;
  assign out_pred  = out_pred_q;
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;
  assign out_imm   = out_imm_q;
  assign out_rd    = out_rd_q;
  assign out_wen   = out_wen_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: scoreboard of expected ID/EX
// slot contents plus direct checks of handshake, stall counter and flush.
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst, rst2, flush, in_valid, in_pred, out_ready;
  logic [31:0] in_pc, in_instr, rf_rd1_data, rf_rd2_data;
  logic [2:0]  fwd_valid, fwd_pending;
  logic [14:0] fwd_addr;
  logic [95:0] fwd_data;

  logic        in_ready, rf_rd1_en, rf_rd2_en, out_valid, out_pred, out_wen;
  logic [4:0]  rf_rd1_addr, rf_rd2_addr, out_rd;
  logic [31:0] out_pc, out_instr, out_op1, out_op2, out_imm;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_rd1_en, s_rd2_en, s_out_valid, s_out_pred, s_out_wen;
  logic [4:0]  s_rd1_addr, s_rd2_addr, s_out_rd;
  logic [31:0] s_out_pc, s_out_instr, s_out_op1, s_out_op2, s_out_imm;
  logic [1:0]  s_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wen;
  } out_t;

  out_t sb[$];
  out_t last_rec;

  id_operand_stage #(.XLEN(32), .RA_W(5), .NUM_FWD(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_pred(in_pred),
    .rf_rd1_en(rf_rd1_en), .rf_rd2_en(rf_rd2_en),
    .rf_rd1_addr(rf_rd1_addr), .rf_rd2_addr(rf_rd2_addr),
    .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_pred(out_pred),
    .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
    .out_rd(out_rd), .out_wen(out_wen), .stall_cnt(stall_cnt)
  );

  id_operand_stage #(.XLEN(32), .RA_W(5), .NUM_FWD(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst2), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_pred(in_pred),
    .rf_rd1_en(s_rd1_en), .rf_rd2_en(s_rd2_en),
    .rf_rd1_addr(s_rd1_addr), .rf_rd2_addr(s_rd2_addr),
    .rf_rd1_data(rf_rd1_data), .rf_rd2_data(rf_rd2_data),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_out_pc), .out_instr(s_out_instr), .out_pred(s_out_pred),
    .out_op1(s_out_op1), .out_op2(s_out_op2), .out_imm(s_out_imm),
    .out_rd(s_out_rd), .out_wen(s_out_wen), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic out_t sample();
    out_t s;
    s.valid = out_valid; s.pc = out_pc; s.instr = out_instr; s.pred = out_pred;
    s.op1 = out_op1; s.op2 = out_op2; s.imm = out_imm; s.rd = out_rd; s.wen = out_wen;
    return s;
  endfunction

  function automatic out_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic pred, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [31:0] imm,
                              input logic [4:0] rd, input logic wen);
    out_t s;
    s.valid = 1'b1; s.pc = pc; s.instr = instr; s.pred = pred;
    s.op1 = op1; s.op2 = op2; s.imm = imm; s.rd = rd; s.wen = wen;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    fwd_valid = '0; fwd_pending = '0; fwd_addr = '0; fwd_data = '0;
  endtask

  task automatic set_fwd(input int ch, input logic v, input logic p,
                         input logic [4:0] a, input logic [31:0] d);
    fwd_valid[ch] = v;
    fwd_pending[ch] = p;
    fwd_addr[ch*5 +: 5] = a;
    fwd_data[ch*32 +: 32] = d;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
    in_valid = 1'b1; in_pc = pc; in_instr = instr; in_pred = pred;
  endtask

  task automatic test_reset();
    out_t obs, exp;
    rst = 1'b0; rst2 = 1'b0; flush = 1'b0; out_ready = 1'b1;
    rf_rd1_data = 32'h11; rf_rd2_data = 32'h22;
    clear_fwd();
    present(32'h0, 32'h00500093, 1'b0);
    for (int c = 0; c < 2; c++) begin
      tick();
      obs = sample();
      n_cmp++;
      if (obs !== '0) begin
        n_bad++; $display("FAIL reset_outputs cyc=%0d got=%h want=0", c, obs);
      end
      n_cmp++;
      if (stall_cnt !== 16'd0) begin
        n_bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt);
      end
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
      end
    end
    rst = 1'b1; rst2 = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL addi_in_ready got=%b want=1", in_ready);
    end
    n_cmp++;
    if ({rf_rd1_en, rf_rd1_addr, rf_rd2_en} !== {1'b1, 5'd0, 1'b0}) begin
      n_bad++; $display("FAIL addi_rf_ports got=%b/%0d/%b want=1/0/0", rf_rd1_en, rf_rd1_addr, rf_rd2_en);
    end
    sb.push_back(mk(32'h0, 32'h00500093, 1'b0, 32'h0, 32'h5, 32'h5, 5'd1, 1'b1));
    tick();
    exp = sb.pop_front(); obs = sample(); last_rec = exp;
    n_cmp++;
    if (obs !== exp) begin
      n_bad++; $display("FAIL addi_accept got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_priority_fwd();
    out_t obs, exp;
    // ADD x3,x1,x2: ch2 writes x1, ch0 and ch1 both write x2 (ch0 wins)
    present(32'h100, 32'h002081B3, 1'b1);
    set_fwd(2, 1'b1, 1'b0, 5'd1, 32'hAA);
    set_fwd(0, 1'b1, 1'b0, 5'd2, 32'hB0);
    set_fwd(1, 1'b1, 1'b0, 5'd2, 32'hB1);
    #1;
    n_cmp++;
    if ({rf_rd1_addr, rf_rd2_addr, rf_rd2_en} !== {5'd1, 5'd2, 1'b1}) begin
      n_bad++; $display("FAIL add_rf_ports got=%0d/%0d/%b want=1/2/1", rf_rd1_addr, rf_rd2_addr, rf_rd2_en);
    end
    sb.push_back(mk(32'h100, 32'h002081B3, 1'b1, 32'hAA, 32'hB0, 32'h0, 5'd3, 1'b1));
    tick();
    exp = sb.pop_front(); obs = sample();
    n_cmp++;
    if (obs !== exp) begin
      n_bad++; $display("FAIL fwd_priority got=%h want=%h", obs, exp);
    end
    // no channel matches: regfile data
    clear_fwd();
    present(32'h104, 32'h002081B3, 1'b0);
    sb.push_back(mk(32'h104, 32'h002081B3, 1'b0, 32'h11, 32'h22, 32'h0, 5'd3, 1'b1));
    tick();
    exp = sb.pop_front(); obs = sample();
    n_cmp++;
    if (obs !== exp) begin
      n_bad++; $display("FAIL fwd_regfile got=%h want=%h", obs, exp);
    end
    // younger ready producer shadows an older pending one
    set_fwd(0, 1'b1, 1'b0, 5'd1, 32'hC0);
    set_fwd(1, 1'b1, 1'b1, 5'd1, 32'hC1);
    present(32'h108, 32'h002081B3, 1'b0);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL fwd_shadow_ready got=%b want=1", in_ready);
    end
    sb.push_back(mk(32'h108, 32'h002081B3, 1'b0, 32'hC0, 32'h22, 32'h0, 5'd3, 1'b1));
    tick();
    exp = sb.pop_front(); obs = sample();
    n_cmp++;
    if (obs !== exp) begin
      n_bad++; $display("FAIL fwd_shadow got=%h want=%h", obs, exp);
    end
    clear_fwd();
  endtask

  task automatic test_load_use();
    out_t obs, exp;
    logic [15:0] s0;
    s0 = stall_cnt;
    present(32'h200, 32'h0000A203, 1'b0);
    set_fwd(0, 1'b1, 1'b1, 5'd1, 32'hDEAD);
    set_fwd(1, 1'b1, 1'b0, 5'd1, 32'h5555);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL loaduse_in_ready cyc=%0d got=%b want=0", c, in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL loaduse_bubble cyc=%0d got=%b want=0", c, out_valid);
      end
    end
    n_cmp++;
    if (stall_cnt !== s0 + 16'd3) begin
      n_bad++; $display("FAIL loaduse_stall_cnt got=%0d want=%0d", stall_cnt, s0 + 16'd3);
    end
    set_fwd(0, 1'b1, 1'b0, 5'd1, 32'h1000);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL loaduse_release got=%b want=1", in_ready);
    end
    sb.push_back(mk(32'h200, 32'h0000A203, 1'b0, 32'h1000, 32'h0, 32'h0, 5'd4, 1'b1));
    tick();
    exp = sb.pop_front(); obs = sample(); last_rec = exp;
    n_cmp++;
    if (obs !== exp) begin
      n_bad++; $display("FAIL loaduse_accept got=%h want=%h", obs, exp);
    end
    n_cmp++;
    if (stall_cnt !== s0 + 16'd3) begin
      n_bad++; $display("FAIL loaduse_cnt_after got=%0d want=%0d", stall_cnt, s0 + 16'd3);
    end
    clear_fwd();
  endtask

  task automatic test_backpressure();
    out_t obs, exp;
    out_ready = 1'b0;
    present(32'h300, 32'h00700293, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", c, in_ready);
      end
      tick();
      obs = sample();
      n_cmp++;
      if (obs !== last_rec) begin
        n_bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", c, obs, last_rec);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release got=%b want=1", in_ready);
    end
    sb.push_back(mk(32'h300, 32'h00700293, 1'b1, 32'h0, 32'h7, 32'h7, 5'd5, 1'b1));
    tick();
    exp = sb.pop_front(); obs = sample();
    n_cmp++;
    if (obs !== exp) begin
      n_bad++; $display("FAIL bp_accept got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_flush();
    logic [15:0] s0;
    s0 = stall_cnt;
    out_ready = 1'b0;
    present(32'h400, 32'h0000A203, 1'b0);
    set_fwd(0, 1'b1, 1'b1, 5'd1, 32'h0);
    flush = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_kill got=%b want=0", out_valid);
    end
    n_cmp++;
    if (stall_cnt !== s0) begin
      n_bad++; $display("FAIL flush_stall_cnt got=%0d want=%0d", stall_cnt, s0);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    clear_fwd();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_idle got=%b want=0", out_valid);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] s0;
    logic [1:0]  want;
    rst2 = 1'b0;
    tick();
    n_cmp++;
    if (s_stall_cnt !== 2'd0) begin
      n_bad++; $display("FAIL sat_reset got=%0d want=0", s_stall_cnt);
    end
    rst2 = 1'b1;
    s0 = stall_cnt;
    present(32'h500, 32'h0000A203, 1'b0);
    set_fwd(0, 1'b1, 1'b1, 5'd1, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      want = (k > 3) ? 2'd3 : 2'(k);
      n_cmp++;
      if (s_stall_cnt !== want) begin
        n_bad++; $display("FAIL sat_count k=%0d got=%0d want=%0d", k, s_stall_cnt, want);
      end
    end
    n_cmp++;
    if (stall_cnt !== s0 + 16'd6) begin
      n_bad++; $display("FAIL wide_count got=%0d want=%0d", stall_cnt, s0 + 16'd6);
    end
    clear_fwd();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_x0();
    out_t obs, exp;
    present(32'h600, 32'h00000033, 1'b0);
    set_fwd(0, 1'b1, 1'b1, 5'd0, 32'hFF);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL x0_no_hazard got=%b want=1", in_ready);
    end
    sb.push_back(mk(32'h600, 32'h00000033, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0));
    tick();
    exp = sb.pop_front(); obs = sample();
    n_cmp++;
    if (obs !== exp) begin
      n_bad++; $display("FAIL x0_operands got=%h want=%h", obs, exp);
    end
    clear_fwd();
  endtask

  task automatic test_back_to_back();
    out_t obs, exp;
    logic [31:0] t_pc[7], t_in[7], t_op1[7], t_op2[7], t_imm[7];
    logic [4:0]  t_rd[7];
    logic        t_wen[7];
    t_pc  = '{32'h700, 32'h704, 32'h708, 32'h70C, 32'h710, 32'h714, 32'h718};
    t_in  = '{32'h123453B7, 32'hFFFFF417, 32'h008000EF, 32'hFFFFFFFF,
              32'h00100013, 32'h00C100E7, 32'hFFF08113};
    t_op1 = '{32'h12345000, 32'hFFFFF000, 32'h0, 32'h0, 32'h0, 32'h11, 32'h11};
    t_op2 = '{32'h0, 32'h704, 32'h0, 32'h0, 32'h1, 32'h0, 32'hFFFFFFFF};
    t_imm = '{32'h12345000, 32'hFFFFF000, 32'h8, 32'h0, 32'h1, 32'hC, 32'hFFFFFFFF};
    t_rd  = '{5'd7, 5'd8, 5'd1, 5'd0, 5'd0, 5'd1, 5'd2};
    t_wen = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      present(t_pc[i], t_in[i], 1'(i));
      sb.push_back(mk(t_pc[i], t_in[i], 1'(i), t_op1[i], t_op2[i], t_imm[i], t_rd[i], t_wen[i]));
      tick();
      exp = sb.pop_front(); obs = sample();
      n_cmp++;
      if (obs !== exp) begin
        n_bad++; $display("FAIL b2b_%0d got=%h want=%h", i, obs, exp);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL b2b_drain got=%b want=0", out_valid);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_pc = '0; in_instr = '0; in_pred = 1'b0;
    test_reset();
    test_priority_fwd();
    test_load_use();
    test_backpressure();
    test_flush();
    test_saturation();
    test_x0();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Parametrised decode/operand stage for the RV32I pipeline, placed between the IF/ID and EX stages.
- Extracts the source registers and immediates from the incoming instruction and drives the regfile read ports.
- Resolves each operand against NUM_FWD prioritised bypass channels, detects use-before-ready hazards, and holds the result in a registered, valid/ready-handshaked ID/EX slot.
- Adds flush support and a saturating stall-cycle counter for performance monitoring.

Parameters:
- XLEN, 32: data/operand width.
- RA_W, 5: register address width.
- NUM_FWD, 3: number of bypass channels; channel 0 is the youngest producer and has the highest priority.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- flush  in  1  kill the held and incoming instruction (branch mispredict)
- in_valid  in  1  IF/ID presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  32  instruction address
- in_instr  in  32  raw instruction
- in_pred  in  1  branch prediction bit
- rf_rd1_en / rf_rd2_en  out  1  regfile read enables
- rf_rd1_addr / rf_rd2_addr  out  RA_W  regfile read addresses
- rf_rd1_data / rf_rd2_data  in  XLEN  regfile read data, combinational, same cycle
- fwd_valid  in  NUM_FWD  channel i carries a register write
- fwd_pending  in  NUM_FWD  channel i result not yet available (load in flight)
- fwd_addr  in  NUM_FWD*RA_W  packed destination addresses; channel i occupies [i*RA_W +: RA_W]
- fwd_data  in  NUM_FWD*XLEN  packed result data
- out_valid  out  1  ID/EX slot holds a valid instruction
- out_ready  in  1  EX consumes the slot
- out_pc, out_instr  out  32  registered copies of the inputs
- out_pred  out  1  registered prediction bit
- out_op1, out_op2  out  XLEN  resolved operands
- out_imm  out  XLEN  selected immediate (I/S/B/U/J by opcode)
- out_rd  out  RA_W  destination register
- out_wen  out  1  instruction writes rd
- stall_cnt  out  CNT_W  saturating count of hazard stall cycles

Behaviour:
- Reset (rst==0 at a clk edge): out_valid, out_wen, all out_* data fields and stall_cnt are cleared to 0. in_ready is 0 while rst==0.
- Source usage by opcode:
  - LUI: op1=U_imm, op2=0.
  - AUIPC: op1=U_imm, op2=pc.
  - JAL: no sources.
  - JALR, LOAD, OP-IMM: use rs1; OP-IMM sets op2=I_imm, the others set op2=0.
  - BRANCH, STORE, OP: use rs1 and rs2.
  - Unknown opcode: no sources, out_wen=0, all fields 0.
- out_wen=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP. out_wen is forced to 0 when rd==0.
- rf_rdN_en and rf_rdN_addr are combinational from in_instr. They are 0 when in_valid==0 or the source is unused.
- Operand resolution (per used source, combinational):
  - Address 0 resolves to 0.
  - Otherwise take the lowest-index channel i with fwd_valid[i] and a matching address.
  - If that channel has fwd_pending[i]=1, raise hazard. The lookup does not fall through to older channels.
  - If it is not pending, use fwd_data[i].
  - If no channel matches, use rf_rdN_data.
  - Unused sources never raise hazard.
- in_ready = rst & ~flush & ~hazard & (~out_valid | out_ready).
- Register update, evaluated in order each clk:
  - flush: out_valid<=0.
  - Otherwise, in_valid & in_ready: load all out_* fields and set out_valid<=1.
  - Otherwise, out_ready: out_valid<=0 (a bubble is inserted on hazard).
  - Otherwise hold.
- Latency: 1 cycle from acceptance to out_valid.
- A stalled instruction stays at the input. Operands are re-resolved every cycle, so data that arrives later is picked up without extra state.
- stall_cnt increments when in_valid & hazard & ~flush, and saturates at 2^CNT_W-1.
- flush and hazard in the same cycle: flush wins and stall_cnt does not increment.
- out_ready asserted while out_valid==0 has no effect.

Decomposition:
- Shared package holds:
  - Opcode constants: OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP.
  - Immediate-format enum: IMM_I/S/B/U/J.
  - XLEN and RA_W defaults.
- Sub-module fwd_resolve(XLEN, RA_W, NUM_FWD): one operand's priority bypass resolution, producing value and hazard. It is instantiated twice.
- Immediate generation and opcode decode stay in the top module.

Test Plan:
- Reset and basic acceptance:
  - Stimulus: hold rst=0 for 2 cycles with in_valid=1, then release; drive ADDI x1,x0,5 (0x00500093) with out_ready=1.
  - Required response: all outputs 0 during reset. One cycle after release, out_valid=1, out_op1=0, out_op2=5, out_rd=1, out_wen=1.
- Priority forwarding:
  - Stimulus: ADD x3,x1,x2 with rf data 0x11/0x22; channel 2 writes x1=0xAA; channels 0 and 1 both write x2, data 0xB0 and 0xB1.
  - Required response: out_op1=0xAA, out_op2=0xB0.
- Load-use stall:
  - Stimulus: channel 0 has pending=1 for x1 while LW x4,0(x1) is presented, held for 3 cycles, then pending=0 with data 0x1000.
  - Required response: in_ready=0 for 3 cycles; bubble (out_valid=0); stall_cnt=3. The instruction is then accepted with out_op1=0x1000.
- Backpressure:
  - Stimulus: out_ready=0 while out_valid=1, with a new instruction at the input.
  - Required response: in_ready=0 and the outputs stay unchanged. When out_ready rises, the next instruction is accepted in that cycle.
- Flush:
  - Stimulus: assert flush with out_valid=1 and a pending hazard present.
  - Required response: out_valid=0 next cycle, in_ready=0 during flush, stall_cnt unchanged.
- Saturation and x0:
  - Stimulus: CNT_W=2 with a hazard for 6 cycles.
  - Required response: stall_cnt stops at 3.
  - Stimulus: ADD x0,x0,x0 with channel 0 writing x0=0xFF.
  - Required response: out_op1=out_op2=0, out_wen=0.
